// File: rtl/dglk_pbk_seq.sv
// Playback sequencer: load, arm and replay a sample buffer at a divided rate.
// Optional external trigger in ARMED when DGLK_PBK_SEQ_EXT_TRG_EN is defined.
module dglk_pbk_seq #(
  parameter int W_APB = 10,
  parameter int W_DIV = 16,
  parameter int W_REP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_load,
  input  logic             cmd_arm,
  input  logic             cmd_stop,
  input  logic             ext_trg,
  input  logic             f_wr,
  input  logic [W_DIV-1:0] div,
  input  logic [W_REP-1:0] reps,
  output logic [2:0]       ctrl,
  output logic [1:0]       state,
  output logic [W_APB:0]   n_smp,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2,
    S_PLAY  = 2'd3
  } st_t;

  localparam logic [W_APB:0] ONE_S = (W_APB+1)'(1);
  localparam logic [W_APB:0] TWO_S = (W_APB+1)'(2);
  localparam logic [W_DIV-1:0] ONE_D = W_DIV'(1);
  localparam logic [W_REP-1:0] ONE_R = W_REP'(1);

  st_t              st_q, st_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [W_APB:0]   n_smp_q, n_smp_d;
  logic [W_APB:0]   idx_q, idx_d;
  logic [W_DIV-1:0] div_q, div_d;
  logic [W_DIV-1:0] dcnt_q, dcnt_d;
  logic [W_REP-1:0] reps_q, reps_d;
  logic [W_REP-1:0] pass_q, pass_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             go;
  logic             last;
  logic             fin;
  logic [W_APB:0]   n_last;

`ifdef DGLK_PBK_SEQ_EXT_TRG_EN
  assign go = ext_trg;
`else
  logic unused_ext_trg;
  assign unused_ext_trg = ext_trg;
  assign go = 1'b1;
`endif

  assign n_last = n_smp_q - ONE_S;
  assign last   = (idx_q == n_last);
  assign fin    = (reps_q != '0) && (pass_q == reps_q);

  // Next-state, counters and registered outputs; cmd_stop overrides all.
  always_comb begin
    st_d    = st_q;
    ctrl_d  = 3'b000;
    n_smp_d = n_smp_q;
    idx_d   = idx_q;
    div_d   = div_q;
    dcnt_d  = dcnt_q;
    reps_d  = reps_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (cmd_stop) begin
      st_d = S_IDLE;
    end else begin
      if (f_wr && st_q != S_LOAD)
        err_d = 1'b1;
      if (cmd_load && st_q != S_IDLE)
        err_d = 1'b1;
      if (cmd_arm && st_q != S_LOAD)
        err_d = 1'b1;
      unique case (st_q)
        S_IDLE: begin
          if (cmd_load) begin
            st_d    = S_LOAD;
            ctrl_d  = 3'b001;
            n_smp_d = '0;
          end
        end
        S_LOAD: begin
          if (f_wr) begin
            if (n_smp_q[W_APB])
              err_d = 1'b1;
            else
              n_smp_d = n_smp_q + ONE_S;
          end
          if (cmd_arm) begin
            if (n_smp_d >= TWO_S)
              st_d = S_ARMED;
            else
              err_d = 1'b1;
          end
        end
        S_ARMED: begin
          if (go) begin
            st_d   = S_PLAY;
            ctrl_d = 3'b010;
            div_d  = div;
            reps_d = reps;
            pass_d = '0;
            idx_d  = '0;
            dcnt_d = '0;
          end
        end
        S_PLAY: begin
          if (fin) begin
            st_d   = S_IDLE;
            done_d = 1'b1;
          end else if (dcnt_q == '0) begin
            ctrl_d[2] = 1'b1;
            dcnt_d    = div_q;
            if (last) begin
              ctrl_d[1] = 1'b1;
              idx_d     = '0;
              pass_d    = pass_q + ONE_R;
            end else begin
              idx_d = idx_q + ONE_S;
            end
          end else begin
            dcnt_d = dcnt_q - ONE_D;
          end
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      ctrl_q  <= 3'b000;
      n_smp_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      dcnt_q  <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ctrl_q  <= ctrl_d;
      n_smp_q <= n_smp_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      dcnt_q  <= dcnt_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign state = st_q;
  assign n_smp = n_smp_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dglk_pbk_seq.sv
// Scoreboard bench for dglk_pbk_seq: expected output events are queued
// by the stimulus and popped by a negedge monitor.
module tb_dglk_pbk_seq;

  localparam int W_APB = 10;
  localparam int W_DIV = 16;
  localparam int W_REP = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_load, cmd_arm, cmd_stop, ext_trg, f_wr;
  logic [W_DIV-1:0] div;
  logic [W_REP-1:0] reps;
  logic [2:0]       ctrl;
  logic [1:0]       state;
  logic [W_APB:0]   n_smp;
  logic             done, err;

  dglk_pbk_seq #(.W_APB(W_APB), .W_DIV(W_DIV), .W_REP(W_REP)) dut (
    .clk(clk), .rst(rst),
    .cmd_load(cmd_load), .cmd_arm(cmd_arm), .cmd_stop(cmd_stop),
    .ext_trg(ext_trg), .f_wr(f_wr), .div(div), .reps(reps),
    .ctrl(ctrl), .state(state), .n_smp(n_smp),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ctrl;
    logic       done;
    logic       err;
    logic [1:0] st;
    int         n;
  } ev_t;

  ev_t exq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Any cycle with a nonzero output must match the head of the queue.
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst && (ctrl != 3'b000 || done || err)) begin
      n_cmp++;
      if (exq.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_event cyc=%0d got ctrl=%b done=%b err=%b st=%0d",
                 cyc, ctrl, done, err, state);
      end else begin
        e = exq.pop_front();
        if (e.cyc != cyc || e.ctrl != ctrl || e.done != done ||
            e.err != err || e.st != state || e.n != int'(n_smp)) begin
          n_mis++;
          $display("FAIL event got cyc=%0d ctrl=%b done=%b err=%b st=%0d n=%0d exp cyc=%0d ctrl=%b done=%b err=%b st=%0d n=%0d",
                   cyc, ctrl, done, err, state, n_smp,
                   e.cyc, e.ctrl, e.done, e.err, e.st, e.n);
        end
      end
    end
  end

  task automatic push(input int c, input logic [2:0] ct, input logic d,
                      input logic er, input logic [1:0] s, input int n);
    ev_t e;
    e.cyc = c; e.ctrl = ct; e.done = d; e.err = er; e.st = s; e.n = n;
    exq.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_only(input int ns);
    cmd_load = 1'b1;
    push(cyc + 1, 3'b001, 1'b0, 1'b0, 2'd1, 0);
    tick(1);
    cmd_load = 1'b0;
    for (int i = 0; i < ns; i++) begin
      f_wr = 1'b1;
      tick(1);
      f_wr = 1'b0;
    end
  endtask

  task automatic arm_play(input int ns, output int e);
    int a;
    a = cyc;
    cmd_arm = 1'b1;
    tick(1);
    cmd_arm = 1'b0;
    e = a + 2;
    push(e, 3'b010, 1'b0, 1'b0, 2'd3, ns);
  endtask

  initial begin
    int e;
    int c;
    rst = 1'b1;
    cmd_load = 0; cmd_arm = 0; cmd_stop = 0; ext_trg = 0; f_wr = 0;
    div = '0; reps = '0;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_nsmp", n_smp, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick(1);

    // 4 samples, div=0, reps=2
    div = 16'd0; reps = 16'd2;
    load_only(4);
    ext_trg = 1'b1;
    arm_play(4, e);
    for (int k = 1; k <= 8; k++)
      push(e + k, (k % 4 == 0) ? 3'b110 : 3'b100, 1'b0, 1'b0, 2'd3, 4);
    push(e + 9, 3'b000, 1'b1, 1'b0, 2'd0, 4);
    ext_trg = 1'b0;
    tick(e + 11 - cyc);

    // 3 samples, div=2, reps=1
    div = 16'd2; reps = 16'd1;
    load_only(3);
    arm_play(3, e);
    for (int k = 0; k < 3; k++)
      push(e + 1 + 3 * k, (k == 2) ? 3'b110 : 3'b100, 1'b0, 1'b0, 2'd3, 3);
    push(e + 8, 3'b000, 1'b1, 1'b0, 2'd0, 3);
    tick(e + 10 - cyc);
    chk("b_state", state, 0);

    // 2 samples, loop forever, stop after 11 p_ena
    div = 16'd0; reps = 16'd0;
    load_only(2);
    arm_play(2, e);
    for (int k = 1; k <= 11; k++)
      push(e + k, (k % 2 == 0) ? 3'b110 : 3'b100, 1'b0, 1'b0, 2'd3, 2);
    tick(e + 11 - cyc);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    chk("c_ctrl", ctrl, 0);
    chk("c_state", state, 0);
    chk("c_nsmp", n_smp, 2);
    chk("c_done", done, 0);
    tick(3);

    // arm with a single sample, then write in IDLE
    load_only(1);
    cmd_arm = 1'b1;
    push(cyc + 1, 3'b000, 1'b0, 1'b1, 2'd1, 1);
    tick(1);
    cmd_arm = 1'b0;
    tick(1);
    chk("d_state", state, 1);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    f_wr = 1'b1;
    push(cyc + 1, 3'b000, 1'b0, 1'b1, 2'd0, 1);
    tick(1);
    f_wr = 1'b0;
    tick(2);
    chk("d_nsmp", n_smp, 1);

    // saturation at 2^W_APB, then cmd_load outside IDLE
    load_only(1024);
    f_wr = 1'b1;
    push(cyc + 1, 3'b000, 1'b0, 1'b1, 2'd1, 1024);
    tick(1);
    f_wr = 1'b0;
    tick(1);
    chk("sat_nsmp", n_smp, 1024);
    cmd_load = 1'b1;
    push(cyc + 1, 3'b000, 1'b0, 1'b1, 2'd1, 1024);
    tick(1);
    cmd_load = 1'b0;
    tick(1);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    tick(2);

    // rst mid-PLAY while p_ena is high
    div = 16'd1; reps = 16'd0;
    load_only(2);
    arm_play(2, e);
    push(e + 1, 3'b100, 1'b0, 1'b0, 2'd3, 2);
    tick(e + 3 - cyc);
    chk("e_pre_ctrl", ctrl, 3'b110);
    rst = 1'b1;
    #1;
    chk("e_ctrl", ctrl, 0);
    chk("e_state", state, 0);
    chk("e_nsmp", n_smp, 0);
    chk("e_done", done, 0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // cmd_stop together with cmd_arm in LOAD
    c = cyc;
    load_only(2);
    cmd_stop = 1'b1;
    cmd_arm = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    cmd_arm = 1'b0;
    chk("f_state", state, 0);
    chk("f_ctrl", ctrl, 0);
    chk("f_err", err, 0);
    chk("f_nsmp", n_smp, 2);
    tick(3);

    n_cmp++;
    if (exq.size() != 0) begin
      n_mis++;
      $display("FAIL missing_events got=%0d pending exp=0 (since cyc %0d)", exq.size(), c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
